tile_pick_input: RTL
====================

Name: tile_pick_input

Overview:
- Upstream input stage for the in-game FSM.
- Conditions the raw select key and the tile-select switches into validated, handshaked tile-pick events.
- Sequences first/second picks and rejects illegal selections before they reach game logic.
- Sits between the top-level KEY/SW inversion and ingameFSM's selection inputs.

Parameters:
NUM_TILES, 10, number of tiles/switches; legal range 2..16.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz).
TIMEOUT_CYCLES, 250000000, cycles allowed between first and second pick (5 s); used only with the optional feature.

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
userquit  input  1  asynchronous active-high reset; also the user-quit signal.
ingameOn  input  1  high while a game is in progress; block is inert when low.
select_raw  input  1  select key, active-high, already inverted, asynchronous to clock.
SW  input  NUM_TILES  tile-select switches; bit i selects tile i.
matched_mask  input  NUM_TILES  bit i high = tile i already matched/removed.
pick_ready  input  1  downstream accepts the offered pick this cycle.
pick_valid  output  1  a pick is offered; held until accepted.
pick_index  output  4  index of the offered tile.
pick_second  output  1  0 = offered pick is the first of a pair; 1 = the second.
first_held  output  1  a first pick has been accepted and the block is awaiting the second.
first_index  output  4  index of the held first pick.
pick_error  output  1  one-cycle pulse when a selection is rejected.

Behaviour:
- Reset (userquit high, async): every register and output goes to 0; state = IDLE; debounced level = 0.
- Synchroniser: select_raw passes through a 2-FF synchroniser.
- Debounce:
  - A counter counts while the synchronised level differs from the debounced level.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Any agreement clears the counter.
- Press event: the debounced level rising 0->1 creates a one-cycle press event.
  - SW is sampled in that same cycle.
- Selection checks, applied to the sampled SW in order; the first failure pulses pick_error the next cycle and leaves the state unchanged:
  - SW == 0, or more than one bit set.
  - The selected bit is set in matched_mask.
  - Second pick only: selected index equals first_index.
- pick_index is the bit position of the single set SW bit.
- States:
  - IDLE: valid press -> OFFER1 the next cycle, with pick_valid=1, pick_second=0.
  - OFFER1: outputs held stable. pick_ready=1 -> WAIT2, first_held=1, first_index latched, pick_valid=0 the next cycle.
  - WAIT2: valid press -> OFFER2 with pick_valid=1, pick_second=1.
  - OFFER2: pick_ready=1 -> IDLE; first_held and pick_valid clear the next cycle.
- Latency: press event in cycle N -> pick_valid high in cycle N+1.
- Presses during OFFER1/OFFER2 are ignored: no queueing, no error.
- pick_valid high with pick_ready high in the same cycle counts as accepted. pick_ready is ignored when pick_valid is low.
- ingameOn low:
  - Synchronous return to IDLE; first_held=0, pick_valid=0, no pick_error.
  - The debouncer keeps running.
  - A press completing while ingameOn is low produces nothing.
- userquit asserted mid-offer: immediate clear. No partial pick survives reset.

Optional Feature:
- Macro: PICK_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT2 and clears on any other state.
  - Reaching TIMEOUT_CYCLES-1 -> state IDLE, first_held=0, and pick_error pulses once.
  - A valid press in the same cycle as the timeout wins; no timeout occurs.
- Undefined: WAIT2 waits indefinitely; no timer logic is synthesised.

Test Plan:
- Reset, then hold select_raw=1 for DEBOUNCE_CYCLES-2 cycles and release -> no pick_valid, no pick_error; a 3-cycle glitch likewise produces nothing.
- ingameOn=1, SW=10'b0000001000, clean press, pick_ready=1 on the second offered cycle:
  - pick_valid high 1 cycle after the debounced edge, pick_index=3, pick_second=0, outputs stable for 2 cycles.
  - Then first_held=1, first_index=3.
- Second press with SW=10'b0000001000 -> pick_error one-cycle pulse, state remains WAIT2.
- Press with SW=10'b0100000000 -> pick_index=8, pick_second=1; after pick_ready, first_held=0 and state is IDLE.
- SW=10'b0000000110, and separately SW=bit 5 with matched_mask bit 5 set -> pick_error pulse each time, pick_valid never asserts.
- In OFFER1 (and separately in WAIT2) drive ingameOn=0 for one cycle -> pick_valid=0 and first_held=0 next cycle. Repeat with async userquit mid-cycle -> outputs 0 immediately.
- With PICK_TIMEOUT_EN and TIMEOUT_CYCLES=100: first pick accepted, no second press -> at cycle 100 of WAIT2, pick_error pulses and first_held drops to 0.

Source files
------------

// File: rtl/tile_pick_input.sv
// tile_pick_input: conditions the raw select key and tile switches into
// validated, handshaked first/second tile-pick events for the in-game FSM.
// The select key is synchronised and debounced, each clean press samples SW,
// and illegal selections produce a one-cycle pick_error pulse.
// Optional feature macro: PICK_TIMEOUT_EN (abandon a held first pick after
// TIMEOUT_CYCLES in WAIT2). With the macro undefined no timer is built.
module tile_pick_input #(
  parameter int unsigned NUM_TILES       = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic                 CLOCK_50,
  input  logic                 userquit,
  input  logic                 ingameOn,
  input  logic                 select_raw,
  input  logic [NUM_TILES-1:0] SW,
  input  logic [NUM_TILES-1:0] matched_mask,
  input  logic                 pick_ready,
  output logic                 pick_valid,
  output logic [3:0]           pick_index,
  output logic                 pick_second,
  output logic                 first_held,
  output logic [3:0]           first_index,
  output logic                 pick_error
);

  if (NUM_TILES < 2 || NUM_TILES > 16 || DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("tile_pick_input: parameter out of range");
  end

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER1 = 2'd1,
    WAIT2  = 2'd2,
    OFFER2 = 2'd3
  } state_t;

  state_t state, state_n;

  logic            sync1, sync2;
  logic            deb, deb_q;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  logic            err_n;
  logic            load_pick;
  logic            load_first;
  logic [3:0]      sel_idx;
  logic            sw_onehot;
  logic            sw_ok;

  // 2-FF synchroniser for the asynchronous select key
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= select_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: level flips after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      deb_q <= deb;
      if (sync2 != deb) begin
        if (db_cnt == DB_MAX) begin
          deb    <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_q;

  // Decode the switch vector: one-hot check, not-yet-matched check, bit position
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (SW[i]) sel_idx = 4'(i);
    end
    sw_onehot = (SW != '0) && ((SW & (SW - NUM_TILES'(1))) == '0);
    sw_ok     = sw_onehot && ((SW & matched_mask) == '0);
  end

`ifdef PICK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // Second-pick timer: runs only while waiting in WAIT2
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      to_cnt <= '0;
    end else if (state == WAIT2 && state_n == WAIT2) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (to_cnt == TO_MAX);
`endif

  // Next-state and pick-load decisions
  always_comb begin
    state_n    = state;
    err_n      = 1'b0;
    load_pick  = 1'b0;
    load_first = 1'b0;
    if (!ingameOn) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (press) begin
            if (sw_ok) begin
              state_n   = OFFER1;
              load_pick = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        OFFER1: begin
          if (pick_ready) begin
            state_n    = WAIT2;
            load_first = 1'b1;
          end
        end
        WAIT2: begin
          // A valid press beats a simultaneous timeout
          if (press && sw_ok && (sel_idx != first_index)) begin
            state_n   = OFFER2;
            load_pick = 1'b1;
          end else begin
            if (press) err_n = 1'b1;
`ifdef PICK_TIMEOUT_EN
            if (to_hit) begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
`endif
          end
        end
        OFFER2: begin
          if (pick_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, offered index, held first index and error pulse registers
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state       <= IDLE;
      pick_index  <= '0;
      first_index <= '0;
      pick_error  <= 1'b0;
    end else begin
      state      <= state_n;
      pick_error <= err_n;
      if (load_pick)  pick_index  <= sel_idx;
      if (load_first) first_index <= pick_index;
    end
  end

  assign pick_valid  = (state == OFFER1) || (state == OFFER2);
  assign pick_second = (state == OFFER2);
  assign first_held  = (state == WAIT2) || (state == OFFER2);

endmodule
